// File: rtl/mul_div_unit.sv
// mul_div_unit - iterative 32x32 multiply / divide for the EX stage.
//
// Accepts MULT/MULTU/DIV/DIVU while idle, iterates one bit per cycle for 32
// cycles, then applies the sign fixup and writes the architectural HI/LO pair.
//
// Ports:
//   clk_i    - clock, all state updates on the rising edge
//   rst_i    - synchronous active-low reset
//   start_i  - operation request, only looked at while idle
//   op_i     - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   data1_i  - rs: multiplicand / dividend
//   data2_i  - rt: multiplier / divisor
//   busy_o   - operation in flight (not asserted in the issue cycle)
//   done_o   - one-cycle pulse when hi_o/lo_o take a new result
//   hi_o     - product[63:32] / remainder
//   lo_o     - product[31:0]  / quotient
module mul_div_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  // Operation captured at issue; magnitudes only, signs kept separately.
  typedef struct packed {
    logic        is_div;
    logic        neg_q;    // negate product / quotient
    logic        neg_r;    // negate remainder
    logic        div_zero;
    logic [31:0] a_raw;    // dividend as issued, returned on divide-by-zero
    logic [31:0] opnd;     // multiplicand (mul) or divisor magnitude (div)
  } md_req_t;

  state_t      state_q, state_d;
  md_req_t     req_q, req_d;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;      // mul: {partial product, multiplier}; div: quotient in [31:0]
  logic [32:0] rem_q;      // div partial remainder
  logic        done_q;
  logic [31:0] hi_q, lo_q;

  // ---------------- issue-time operand conditioning ----------------
  logic        sgn_op, s1, s2;
  logic [31:0] mag1, mag2;

  always_comb begin
    sgn_op = ~op_i[0];
    s1     = sgn_op & data1_i[31];
    s2     = sgn_op & data2_i[31];
    // |0x80000000| stays 0x80000000, which is the right unsigned magnitude.
    mag1   = s1 ? -data1_i : data1_i;
    mag2   = s2 ? -data2_i : data2_i;

    req_d.is_div   = op_i[1];
    req_d.neg_q    = s1 ^ s2;
    req_d.neg_r    = s1;
    req_d.div_zero = op_i[1] & (data2_i == 32'd0);
    req_d.a_raw    = data1_i;
    req_d.opnd     = op_i[1] ? mag2 : mag1;
  end

  // ---------------- one iteration ----------------
  logic [32:0] mul_sum;
  logic [32:0] rem_sh, rem_nx;
  logic        q_bit;

  always_comb begin
    // Shift-add, multiplier consumed LSB first from acc_q[31:0].
    mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, req_q.opnd} : 33'd0);
    // Restoring division, dividend bits consumed MSB first from acc_q[31:0].
    rem_sh  = {rem_q[31:0], acc_q[31]};
    q_bit   = (rem_sh >= {1'b0, req_q.opnd});
    rem_nx  = q_bit ? (rem_sh - {1'b0, req_q.opnd}) : rem_sh;
  end

  // ---------------- sign fixup ----------------
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    prod_fix = req_q.neg_q ? -acc_q : acc_q;
    quo_fix  = req_q.neg_q ? -acc_q[31:0] : acc_q[31:0];
    rem_fix  = req_q.neg_r ? -rem_q[31:0] : rem_q[31:0];
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = CALC;
      CALC:    if (cnt_q == 5'd0) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      req_q  <= '0;
      cnt_q  <= 5'd0;
      acc_q  <= 64'd0;
      rem_q  <= 33'd0;
      done_q <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          req_q <= req_d;
          cnt_q <= 5'd31;
          rem_q <= 33'd0;
          acc_q <= {32'd0, (op_i[1] ? mag1 : mag2)};
        end
        CALC: begin
          cnt_q <= (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
          if (req_q.is_div) begin
            rem_q <= rem_nx;
            acc_q <= {32'd0, acc_q[30:0], q_bit};
          end else begin
            acc_q <= {mul_sum, acc_q[31:1]};
          end
        end
        FIX: begin
          done_q <= 1'b1;
          if (!req_q.is_div) begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end else if (req_q.div_zero) begin
            hi_q <= req_q.a_raw;
            lo_q <= 32'hFFFF_FFFF;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  // state_q is a flop, so busy_o is registered: high from the edge after
  // issue through the FIX cycle.
  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit - randomized self-checking bench for mul_div_unit.
// A cycle-count model with plain-arithmetic results is compared against the
// DUT every cycle; directed cases pin literal results and latencies.
module tb_mul_div_unit;

  localparam logic [1:0] MULT = 2'd0, MULTU = 2'd1, DIV = 2'd2, DIVU = 2'd3;

  logic        clk = 1'b0;
  logic        rst_i, start_i;
  logic [1:0]  op_i;
  logic [31:0] data1_i, data2_i;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;

  mul_div_unit dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .data1_i(data1_i), .data2_i(data2_i),
    .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference ----------------
  function automatic logic [63:0] ref_result(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    logic [31:0] uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MULT:    begin sq = sa * sb; p = sq; end
      MULTU:   p = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else if (op == DIV) begin
          sq = sa / sb; sr = sa % sb;
          p = {sr[31:0], sq[31:0]};
        end else begin
          uq = a / b; ur = a % b;
          p = {ur, uq};
        end
      end
    endcase
    return p;
  endfunction

  // Model: an accepted op keeps the unit busy for 33 cycles, then the
  // result appears together with a one-cycle done.
  int          m_cnt = 0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_pend = '0;

  always @(posedge clk) begin
    if (!rst_i) begin
      m_cnt <= 0; m_busy <= 1'b0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (start_i) begin
          m_cnt  <= 33;
          m_busy <= 1'b1;
          m_pend <= ref_result(op_i, data1_i, data2_i);
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_hi   <= m_pend[63:32];
          m_lo   <= m_pend[31:0];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_chk++;
      if ({busy_o, done_o, hi_o, lo_o} !== {m_busy, m_done, m_hi, m_lo}) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t dut busy=%0b done=%0b hi=%h lo=%h, model busy=%0b done=%0b hi=%h lo=%h",
                 $time, busy_o, done_o, hi_o, lo_o, m_busy, m_done, m_hi, m_lo);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; holds start for one edge.
  task automatic do_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1; op_i = op; data1_i = a; data2_i = b;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 0; i < 80; i++) begin
      if (done_o === 1'b1) begin cyc = i; return; end
      @(negedge clk);
    end
    n_chk++; n_fail++;
    $display("FAIL done_timeout: got no done within 80 cycles, expected done");
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int c;
    do_start(op, a, b);
    wait_done(c);
    chk({nm, "_lat"}, c, 33);
    chk({nm, "_hi"}, hi_o, ehi);
    chk({nm, "_lo"}, lo_o, elo);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      4: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] r;
    int c;
    rst_i = 1'b0; start_i = 1'b0; op_i = '0; data1_i = '0; data2_i = '0;

    // Pin the reference model with hand values.
    r = ref_result(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("ref_multu", r[63:32] ^ r[31:0], 32'hFFFF_FFFF);
    r = ref_result(DIV, -32'sd7, 32'd2);
    chk("ref_div_lo", r[31:0], 32'hFFFF_FFFD);
    chk("ref_div_hi", r[63:32], 32'hFFFF_FFFF);

    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    rst_i = 1'b1;
    repeat (50) @(negedge clk);
    chk("idle_hi", hi_o, 32'd0);
    chk("idle_busy", {31'd0, busy_o}, 32'd0);

    run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg", MULT, -32'sd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("div_neg", DIV, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("divu_z", DIVU, 32'h1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div_z_neg", DIV, -32'sd9, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);

    // Starts while busy are ignored.
    do_start(DIV, -32'sd100, 32'd7);
    repeat (4) @(negedge clk);
    do_start(MULTU, 32'd3, 32'd3);
    repeat (14) @(negedge clk);
    do_start(DIVU, 32'd50, 32'd5);
    wait_done(c);
    chk("ign_hi", hi_o, 32'hFFFF_FFFE);
    chk("ign_lo", lo_o, 32'hFFFF_FFF2);
    // Back-to-back issue in the done cycle.
    do_start(MULT, 32'd7, -32'sd8);
    wait_done(c);
    chk("b2b_lat", c, 33);
    chk("b2b_hi", hi_o, 32'hFFFF_FFFF);
    chk("b2b_lo", lo_o, 32'hFFFF_FFC8);
    @(negedge clk);

    // Reset aborts an in-flight divide.
    do_start(DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_hi", hi_o, 32'd0);
    chk("abort_lo", lo_o, 32'd0);
    repeat (40) @(negedge clk);
    chk("abort_nodone", {31'd0, done_o}, 32'd0);
    run_op("after_rst", MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int n = 0; n < 150; n++) begin
      do_start(2'($urandom_range(0, 3)), pick(), pick());
      if ($urandom_range(0, 9) < 3) begin
        repeat ($urandom_range(1, 25)) @(negedge clk);
        do_start(2'($urandom_range(0, 3)), pick(), pick());
      end
      wait_done(c);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
